// File: rtl/x25519_operand_loader.sv
// Byte-stream loader for the curve25519 ladder: gathers a 32-byte scalar and a 32-byte
// u-coordinate (little-endian), optionally clamps the scalar, then starts the core and waits for done.
module x25519_operand_loader #(
  parameter bit CLAMP = 1'b1
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         in_valid,
  input  logic [7:0]   in_data,
  output logic         in_ready,
  input  logic         core_done,
  output logic         start,
  output logic [254:0] n,
  output logic [254:0] q,
  output logic         busy
);

  typedef enum logic [1:0] {
    LOAD_N,
    LOAD_Q,
    START,
    WAIT
  } state_t;

  state_t         state_reg;
  state_t         state_next;
  logic [4:0]     count_reg;
  logic [254:0]   n_reg;
  logic [254:0]   n_next;
  logic [254:0]   q_reg;
  logic [254:0]   q_next;
  logic           accept;
  logic           last_byte;
  logic           clamp_en;
  logic [31:0]    n_we;
  logic [31:0]    q_we;

  assign accept    = in_valid && in_ready;
  assign last_byte = (count_reg == 5'd31);

  // Clamping is folded into the edge that accepts the final u byte, so n is final in START.
  assign clamp_en  = CLAMP && accept && (state_reg == LOAD_Q) && last_byte;

  genvar gi;
  generate
    for (gi = 0; gi < 32; gi++) begin : g_lane
      assign n_we[gi] = accept && (state_reg == LOAD_N) && (count_reg == 5'(gi));
      assign q_we[gi] = accept && (state_reg == LOAD_Q) && (count_reg == 5'(gi));
    end
  endgenerate

  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg <= LOAD_N;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    in_ready   = 1'b0;
    start      = 1'b0;
    busy       = 1'b0;
    case (state_reg)
      LOAD_N: begin
        in_ready = 1'b1;
        if (in_valid && last_byte) state_next = LOAD_Q;
      end
      LOAD_Q: begin
        in_ready = 1'b1;
        if (in_valid && last_byte) state_next = START;
      end
      START: begin
        start      = 1'b1;
        busy       = 1'b1;
        state_next = WAIT;
      end
      WAIT: begin
        busy = 1'b1;
        if (core_done) state_next = LOAD_N;
      end
      default: state_next = LOAD_N;
    endcase
  end

  // The 5-bit counter wraps 31->0 exactly on the phase-ending byte of each operand.
  always_ff @(posedge clock) begin
    if (reset) begin
      count_reg <= 5'd0;
    end else if (accept) begin
      count_reg <= count_reg + 5'd1;
    end
  end

  always_comb begin
    n_next = n_reg;
    q_next = q_reg;
    for (int i = 0; i < 31; i++) begin
      if (n_we[i]) n_next[8*i +: 8] = in_data;
      if (q_we[i]) q_next[8*i +: 8] = in_data;
    end
    // Bit 7 of the top byte is bit 255 of each operand and is dropped.
    if (n_we[31]) n_next[254:248] = in_data[6:0];
    if (q_we[31]) q_next[254:248] = in_data[6:0];
    if (clamp_en) begin
      n_next[254] = 1'b1;
      n_next[2:0] = 3'b000;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      n_reg <= '0;
      q_reg <= '0;
    end else begin
      n_reg <= n_next;
      q_reg <= q_next;
    end
  end

  assign n = n_reg;
  assign q = q_reg;

endmodule

// File: tb/tb_x25519_operand_loader.sv
// Self-checking bench: a clamping and a raw loader driven in lockstep, checked against
// directed vectors and a plain-arithmetic operand model under randomized stalls.
module tb_x25519_operand_loader;

  logic         clock = 1'b0;
  logic         reset;
  logic         in_valid;
  logic [7:0]   in_data;
  logic         core_done;
  logic         in_ready, start, busy;
  logic [254:0] n, q;
  logic         in_ready0, start0, busy0;
  logic [254:0] n0, q0;

  int tests = 0;
  int fails = 0;
  int start_count = 0;
  logic [254:0] mock_q = '0;

  always #5 clock = ~clock;

  x25519_operand_loader #(.CLAMP(1'b1)) dut (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .core_done(core_done), .start(start),
    .n(n), .q(q), .busy(busy)
  );

  x25519_operand_loader #(.CLAMP(1'b0)) dut0 (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready0), .core_done(core_done), .start(start0),
    .n(n0), .q(q0), .busy(busy0)
  );

  // Mock core: latches q on the start pulse, later returned as its "result".
  always @(negedge clock) begin
    if (start === 1'b1) begin
      start_count <= start_count + 1;
      mock_q      <= q;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [255:0] scalar;
    logic [255:0] u;
    logic [254:0] exp_n1;
    logic [254:0] exp_n0;
    logic [254:0] exp_q;
  } vec_t;

  vec_t vecs[4];

  task automatic check_val(input string name, input logic [254:0] act, input logic [254:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic check_bit(input string name, input logic act, input logic exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %b, expected %b", name, act, exp);
    end
  endtask

  // Operands from the byte rules: value modulo 2^255, clamp = clear low 3 bits and set bit 254.
  function automatic logic [254:0] model_n(input logic [255:0] s, input bit clamp);
    logic [254:0] v;
    v = s[254:0];
    if (clamp) begin
      v = v - (v % 255'd8);
      v = v | (255'd1 << 254);
    end
    return v;
  endfunction

  function automatic logic [254:0] model_q(input logic [255:0] u);
    return u[254:0];
  endfunction

  task automatic idle(input int cycles);
    in_valid = 1'b0;
    in_data  = 8'($urandom);
    repeat (cycles) @(negedge clock);
  endtask

  task automatic send_byte(input logic [7:0] b);
    int waitc;
    waitc    = 0;
    in_valid = 1'b1;
    in_data  = b;
    while (in_ready !== 1'b1 && waitc < 100) begin
      @(negedge clock);
      waitc++;
    end
    if (waitc >= 100) begin
      tests++;
      fails++;
      $display("FAIL send_byte: in_ready stuck low, byte %h", b);
    end
    @(negedge clock);
    in_valid = 1'b0;
  endtask

  task automatic send_op(input logic [255:0] s, input logic [255:0] u, input bit stall);
    for (int k = 0; k < 32; k++) begin
      if (stall && ($urandom % 3 == 0)) idle(int'($urandom % 3) + 1);
      send_byte(s[8*k +: 8]);
    end
    for (int k = 0; k < 32; k++) begin
      if (stall && ($urandom % 3 == 0)) idle(int'($urandom % 3) + 1);
      send_byte(u[8*k +: 8]);
    end
  endtask

  task automatic run_op(input string tag, input logic [255:0] s, input logic [255:0] u,
                        input logic [254:0] en1, input logic [254:0] en0,
                        input logic [254:0] eq, input bit stall);
    int sc0;
    sc0 = start_count;
    send_op(s, u, stall);
    check_bit({tag, " start"}, start, 1'b1);
    check_bit({tag, " start0"}, start0, 1'b1);
    check_bit({tag, " ready in START"}, in_ready, 1'b0);
    check_bit({tag, " busy in START"}, busy, 1'b1);
    check_val({tag, " n clamp"}, n, en1);
    check_val({tag, " n raw"}, n0, en0);
    check_val({tag, " q"}, q, eq);
    check_val({tag, " q raw dut"}, q0, eq);
    in_valid = 1'b1;
    in_data  = 8'hAA;
    for (int c = 0; c < 3; c++) begin
      @(negedge clock);
      check_bit({tag, " start low in WAIT"}, start, 1'b0);
      check_bit({tag, " ready in WAIT"}, in_ready, 1'b0);
      check_bit({tag, " busy in WAIT"}, busy, 1'b1);
      check_val({tag, " n held"}, n, en1);
      check_val({tag, " q held"}, q0, eq);
    end
    core_done = 1'b1;
    @(negedge clock);
    core_done = 1'b0;
    in_valid  = 1'b0;
    check_bit({tag, " busy after done"}, busy, 1'b0);
    check_bit({tag, " ready after done"}, in_ready, 1'b1);
    check_val({tag, " start pulses"}, 255'(start_count - sc0), 255'd1);
    check_val({tag, " mock core result"}, mock_q, eq);
    check_val({tag, " n after done"}, n0, en0);
  endtask

  initial begin
    logic [255:0] rs, ru;
    logic [254:0] prev_n, prev_n0;
    reset     = 1'b1;
    in_valid  = 1'b0;
    in_data   = 8'h00;
    core_done = 1'b0;

    vecs[0] = '{256'h0, 256'h9, {1'b1, 254'h0}, 255'h0, 255'h9};
    vecs[1] = '{{256{1'b1}}, {256{1'b1}}, {1'b1, {251{1'b1}}, 3'b000}, {255{1'b1}}, {255{1'b1}}};
    vecs[2] = '{256'h1234, 256'h5678, {1'b1, 254'h1230}, 255'h1234, 255'h5678};
    vecs[3] = '{{1'b1, 255'h0F}, {1'b1, 255'h7}, {1'b1, 254'h08}, 255'h0F, 255'h7};

    repeat (2) @(negedge clock);
    check_bit("reset in_ready", in_ready, 1'b1);
    check_bit("reset start", start, 1'b0);
    check_bit("reset busy", busy, 1'b0);
    check_val("reset n", n, 255'h0);
    check_val("reset q", q, 255'h0);
    reset = 1'b0;

    for (int i = 0; i < 4; i++) begin
      run_op($sformatf("vec%0d", i), vecs[i].scalar, vecs[i].u,
             vecs[i].exp_n1, vecs[i].exp_n0, vecs[i].exp_q, 1'b0);
      $display("[TB] vector %0d done", i);
    end

    // core_done raised during START is ignored; the loader still spends one cycle in WAIT.
    send_op(vecs[2].scalar, vecs[2].u, 1'b0);
    core_done = 1'b1;
    @(negedge clock);
    check_bit("done in START: busy", busy, 1'b1);
    check_bit("done in START: ready", in_ready, 1'b0);
    check_bit("done in START: start", start, 1'b0);
    @(negedge clock);
    core_done = 1'b0;
    check_bit("done in WAIT: busy", busy, 1'b0);
    check_bit("done in WAIT: ready", in_ready, 1'b1);
    $display("[TB] done-during-START sequence done");

    // Next accepted byte lands in n[7:0].
    prev_n  = n;
    prev_n0 = n0;
    in_valid = 1'b1;
    in_data  = 8'h5A;
    @(negedge clock);
    in_valid = 1'b0;
    check_val("next byte raw", n0, {prev_n0[254:8], 8'h5A});
    check_val("next byte clamp dut", n, {prev_n[254:8], 8'h5A});
    $display("[TB] next-byte sequence done");

    // Reset mid-load after 10 accepted bytes.
    for (int k = 0; k < 9; k++) send_byte(8'($urandom));
    reset = 1'b1;
    for (int c = 0; c < 2; c++) begin
      @(negedge clock);
      check_bit("mid-load reset start", start, 1'b0);
      check_bit("mid-load reset busy", busy, 1'b0);
      check_bit("mid-load reset ready", in_ready, 1'b1);
      check_val("mid-load reset n", n, 255'h0);
      check_val("mid-load reset q", q0, 255'h0);
    end
    reset = 1'b0;
    run_op("after mid reset", vecs[3].scalar, vecs[3].u,
           vecs[3].exp_n1, vecs[3].exp_n0, vecs[3].exp_q, 1'b0);
    $display("[TB] mid-load reset sequence done");

    // Reset during WAIT; a later core_done must be ignored.
    send_op(vecs[0].scalar, vecs[0].u, 1'b0);
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    check_bit("WAIT reset ready", in_ready, 1'b1);
    check_bit("WAIT reset busy", busy, 1'b0);
    check_bit("WAIT reset start", start, 1'b0);
    core_done = 1'b1;
    @(negedge clock);
    core_done = 1'b0;
    check_bit("stale done ready", in_ready, 1'b1);
    check_bit("stale done busy", busy, 1'b0);
    run_op("after WAIT reset", vecs[1].scalar, vecs[1].u,
           vecs[1].exp_n1, vecs[1].exp_n0, vecs[1].exp_q, 1'b1);
    $display("[TB] WAIT reset sequence done");

    for (int t = 0; t < 20; t++) begin
      for (int w = 0; w < 8; w++) begin
        rs[32*w +: 32] = $urandom;
        ru[32*w +: 32] = $urandom;
      end
      run_op($sformatf("rand%0d", t), rs, ru, model_n(rs, 1'b1), model_n(rs, 1'b0),
             model_q(ru), 1'b1);
      $display("[TB] random op %0d done", t);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
